// File: rtl/logic_analyzer_readout.sv
// Read side of the logic analyzer capture FIFO: drains 64-bit words and streams
// them out as gap-free 16-bit halfwords (LSB halfword first) with a word count.
module logic_analyzer_readout #(
   parameter int COUNT_WIDTH = 11,
   parameter int BLOCK_WORDS = 256
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   clear,
   input  logic                   fifo_empty,
   input  logic [COUNT_WIDTH-1:0] fifo_rd_count,
   input  logic [63:0]            fifo_data_in,
   output logic                   fifo_rd_en,
   input  logic                   pipe_rd,
   output logic [15:0]            pipe_data,
   output logic                   pipe_valid,
   output logic                   pipe_ready,
   output logic [COUNT_WIDTH+2:0] words_available,
   output logic                   underflow
);

   localparam int WW = COUNT_WIDTH + 3;
   localparam logic [WW-1:0] BLK = WW'(BLOCK_WORDS);

   logic [63:0]   a_word_q, a_word_d;
   logic [1:0]    a_idx_q, a_idx_d;
   logic          a_vld_q, a_vld_d;
   logic [63:0]   p_word_q, p_word_d;
   logic          p_vld_q, p_vld_d;
   logic          f_q, f_d;
   logic          und_q, und_d;
   logic [WW-1:0] words_q, words_d;
   logic          ready_q, ready_d;
   logic [3:0]    held;

   // Reset gating keeps the strobe low for the whole time reset_n is asserted.
   assign fifo_rd_en = reset_n && !fifo_empty && !f_q && !clear && !(a_vld_q && p_vld_q);

   assign pipe_data       = a_vld_q ? a_word_q[16*a_idx_q +: 16] : 16'h0;
   assign pipe_valid      = a_vld_q;
   assign pipe_ready      = ready_q;
   assign words_available = words_q;
   assign underflow       = und_q;

   assign held = (a_vld_q ? (4'd4 - {2'b00, a_idx_q}) : 4'd0)
               + (p_vld_q ? 4'd4 : 4'd0)
               + (f_q     ? 4'd4 : 4'd0);

   always_comb begin
      a_word_d = a_word_q;
      a_idx_d  = a_idx_q;
      a_vld_d  = a_vld_q;
      p_word_d = p_word_q;
      p_vld_d  = p_vld_q;
      f_d      = f_q;
      und_d    = und_q;
      words_d  = {1'b0, fifo_rd_count, 2'b00} + WW'(held);
      ready_d  = (words_d >= BLK);
      if (clear) begin
         a_vld_d = 1'b0;
         a_idx_d = 2'd0;
         p_vld_d = 1'b0;
         f_d     = 1'b0;
         und_d   = 1'b0;
      end else begin
         if (pipe_rd && !a_vld_q) und_d = 1'b1;
         if (pipe_rd && a_vld_q) begin
            if (a_idx_q != 2'd3) begin
               a_idx_d = a_idx_q + 2'd1;
            end else if (p_vld_q) begin
               a_word_d = p_word_q;
               a_idx_d  = 2'd0;
               p_vld_d  = 1'b0;
            end else begin
               a_vld_d = 1'b0;
            end
         end
         // Returning data lands in A whenever A ends this cycle empty, else in P.
         if (f_q) begin
            if (!a_vld_d) begin
               a_word_d = fifo_data_in;
               a_idx_d  = 2'd0;
               a_vld_d  = 1'b1;
            end else begin
               p_word_d = fifo_data_in;
               p_vld_d  = 1'b1;
            end
         end
         f_d = fifo_rd_en;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         a_word_q <= '0;
         a_idx_q  <= '0;
         a_vld_q  <= 1'b0;
         p_word_q <= '0;
         p_vld_q  <= 1'b0;
         f_q      <= 1'b0;
         und_q    <= 1'b0;
         words_q  <= '0;
         ready_q  <= 1'b0;
      end else begin
         a_word_q <= a_word_d;
         a_idx_q  <= a_idx_d;
         a_vld_q  <= a_vld_d;
         p_word_q <= p_word_d;
         p_vld_q  <= p_vld_d;
         f_q      <= f_d;
         und_q    <= und_d;
         words_q  <= words_d;
         ready_q  <= ready_d;
      end
   end

endmodule

// File: tb/tb_logic_analyzer_readout.sv
// Directed bench for logic_analyzer_readout: a halfword-queue model of the
// readout plus a FIFO model, compared every cycle, with literal spot checks.
module tb_logic_analyzer_readout;
   localparam int CW = 11;
   localparam int BW = 256;

   logic          clk = 1'b0;
   logic          reset_n, clear, fifo_empty, fifo_rd_en, pipe_rd;
   logic          pipe_valid, pipe_ready, underflow;
   logic [CW-1:0] fifo_rd_count;
   logic [63:0]   fifo_data_in;
   logic [15:0]   pipe_data;
   logic [CW+2:0] words_available;

   always #5 clk = ~clk;

   logic_analyzer_readout #(.COUNT_WIDTH(CW), .BLOCK_WORDS(BW)) dut (
      .clk(clk), .reset_n(reset_n), .clear(clear), .fifo_empty(fifo_empty),
      .fifo_rd_count(fifo_rd_count), .fifo_data_in(fifo_data_in),
      .fifo_rd_en(fifo_rd_en), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
      .pipe_valid(pipe_valid), .pipe_ready(pipe_ready),
      .words_available(words_available), .underflow(underflow)
   );

   int n_vec = 0;
   int n_bad = 0;

   logic [63:0] fifo_q[$];
   bit          use_force;
   int          force_cnt;
   int          rd_pulses;

   // Model: the block is just a queue of halfwords plus one outstanding read.
   logic [15:0] hq[$];
   bit          m_inflight, m_und, m_rdy, m_rd;
   int          m_words;

   bit          s_rd_en, s_mrd, s_pipe_rd, s_clear, s_rst;
   logic [63:0] s_data;
   int          s_cnt;

   task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %0h, want %0h", nm, $time, act, exp);
      end
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      cmp(nm, act, exp);
   endtask

   function automatic void model_reset();
      hq.delete();
      m_inflight = 1'b0;
      m_und      = 1'b0;
      m_rdy      = 1'b0;
      m_words    = 0;
   endfunction

   task automatic settle();
      fifo_empty    = (fifo_q.size() == 0);
      fifo_rd_count = use_force ? CW'(force_cnt) : CW'(fifo_q.size());
      #1;
      if (!reset_n) model_reset();
      m_rd = reset_n && fifo_q.size() > 0 && !m_inflight && !clear && hq.size() <= 4;
      n_vec++;
      cmp("rd_en",     fifo_rd_en, m_rd);
      cmp("valid",     pipe_valid, hq.size() > 0);
      cmp("data",      pipe_data, (hq.size() > 0) ? hq[0] : 16'h0);
      cmp("words",     words_available, m_words);
      cmp("ready",     pipe_ready, m_rdy);
      cmp("underflow", underflow, m_und);
      s_rd_en   = fifo_rd_en;
      s_mrd     = m_rd;
      s_pipe_rd = pipe_rd;
      s_clear   = clear;
      s_rst     = reset_n;
      s_data    = fifo_data_in;
      s_cnt     = int'(fifo_rd_count);
   endtask

   task automatic tick();
      bit          have_next;
      logic [63:0] nxt_data;
      int          nxt;
      have_next = 1'b0;
      nxt_data  = '0;
      @(posedge clk);
      if (!s_rst) begin
         model_reset();
      end else begin
         nxt = 4 * s_cnt + hq.size() + (m_inflight ? 4 : 0);
         if (s_clear) begin
            hq.delete();
            m_inflight = 1'b0;
            m_und      = 1'b0;
         end else begin
            if (s_pipe_rd) begin
               if (hq.size() > 0) void'(hq.pop_front());
               else m_und = 1'b1;
            end
            if (m_inflight)
               for (int k = 0; k < 4; k++) hq.push_back(s_data[16*k +: 16]);
            m_inflight = s_mrd;
         end
         m_words = nxt;
         m_rdy   = (nxt >= BW);
         if (s_rd_en && fifo_q.size() > 0) begin
            nxt_data  = fifo_q.pop_front();
            have_next = 1'b1;
            rd_pulses++;
         end
      end
      @(negedge clk);
      if (have_next) fifo_data_in = nxt_data;
   endtask

   task automatic cyc();
      settle();
      tick();
   endtask

   task automatic wait_valid(input string nm, output int n);
      n = 0;
      settle();
      while (!pipe_valid && n < 8) begin
         tick();
         settle();
         n++;
      end
      chk(nm, pipe_valid, 1'b1);
   endtask

   task automatic drain(input int k);
      pipe_rd = 1'b1;
      repeat (k) cyc();
      pipe_rd = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [15:0] hw1[4]  = '{16'hCDEF, 16'h89AB, 16'h4567, 16'h0123};
      logic [15:0] bb[12]  = '{16'h4444, 16'h3333, 16'h2222, 16'h1111,
                               16'h8888, 16'h7777, 16'h6666, 16'h5555,
                               16'hCCCC, 16'hBBBB, 16'hAAAA, 16'h9999};
      int n;

      reset_n = 1'b0; clear = 1'b0; pipe_rd = 1'b0;
      use_force = 1'b0; force_cnt = 0; rd_pulses = 0;
      fifo_data_in = '0;
      model_reset();
      @(negedge clk);
      cyc();
      settle();
      chk("rst_valid", pipe_valid, 0);
      chk("rst_data",  pipe_data, 0);
      chk("rst_words", words_available, 0);
      chk("rst_ready", pipe_ready, 0);
      chk("rst_und",   underflow, 0);
      chk("rst_rd_en", fifo_rd_en, 0);
      tick();
      reset_n = 1'b1;
      cyc(); cyc();

      // Single word
      fifo_q.push_back(64'h0123_4567_89AB_CDEF);
      settle();
      chk("t1_rd_en", fifo_rd_en, 1);
      wait_valid("t1_wait", n);
      chk("t1_latency", n, 2);
      for (int i = 0; i < 4; i++) begin
         pipe_rd = 1'b1;
         settle();
         chk("t1_hw", pipe_data, hw1[i]);
         tick();
      end
      pipe_rd = 1'b0;
      settle();
      chk("t1_valid_drop", pipe_valid, 0);
      tick();

      // Back-to-back
      rd_pulses = 0;
      fifo_q.push_back(64'h1111_2222_3333_4444);
      fifo_q.push_back(64'h5555_6666_7777_8888);
      fifo_q.push_back(64'h9999_AAAA_BBBB_CCCC);
      wait_valid("t2_wait", n);
      for (int i = 0; i < 12; i++) begin
         pipe_rd = 1'b1;
         settle();
         chk("t2_valid", pipe_valid, 1);
         chk("t2_hw", pipe_data, bb[i]);
         tick();
      end
      pipe_rd = 1'b0;
      settle();
      chk("t2_underflow", underflow, 0);
      chk("t2_rd_pulses", rd_pulses, 3);
      chk("t2_valid_drop", pipe_valid, 0);
      tick();

      // Underflow
      pipe_rd = 1'b1;
      settle();
      chk("t3_data0", pipe_data, 0);
      tick();
      pipe_rd = 1'b0;
      settle();
      chk("t3_underflow", underflow, 1);
      tick();
      fifo_q.push_back(64'h0123_4567_89AB_CDEF);
      wait_valid("t3_wait", n);
      chk("t3_und_sticky", underflow, 1);
      drain(4);
      clear = 1'b1;
      cyc();
      clear = 1'b0;
      settle();
      chk("t3_und_cleared", underflow, 0);
      tick();

      // Counts
      fifo_q.push_back(64'h0123_4567_89AB_CDEF);
      wait_valid("t4_wait", n);
      pipe_rd = 1'b1; use_force = 1'b1; force_cnt = 64;
      cyc();
      pipe_rd = 1'b0;
      cyc();
      settle();
      chk("t4_words259", words_available, 259);
      chk("t4_ready1", pipe_ready, 1);
      tick();
      force_cnt = 63;
      cyc();
      settle();
      chk("t4_words255", words_available, 255);
      chk("t4_ready0", pipe_ready, 0);
      tick();
      use_force = 1'b0;
      drain(3);
      cyc();

      // Clear in flight
      fifo_q.push_back(64'hDEAD_BEEF_0BAD_F00D);
      fifo_q.push_back(64'hCAFE_F00D_5A5A_A5A5);
      settle();
      chk("t5_rd_en", fifo_rd_en, 1);
      tick();
      clear = 1'b1;
      cyc();
      clear = 1'b0;
      settle();
      chk("t5_valid", pipe_valid, 0);
      chk("t5_refetch", fifo_rd_en, 1);
      tick();
      settle();
      chk("t5_words", words_available, 4);
      tick();
      settle();
      chk("t5_valid_b", pipe_valid, 1);
      chk("t5_data_b", pipe_data, 16'hA5A5);
      tick();
      drain(4);
      cyc();

      // Reset mid-stream
      fifo_q.push_back(64'h0001_0002_0003_0004);
      fifo_q.push_back(64'h0005_0006_0007_0008);
      wait_valid("t6_wait", n);
      drain(2);
      reset_n = 1'b0;
      settle();
      chk("t6_valid", pipe_valid, 0);
      chk("t6_data",  pipe_data, 0);
      chk("t6_words", words_available, 0);
      chk("t6_ready", pipe_ready, 0);
      chk("t6_rd_en", fifo_rd_en, 0);
      tick();
      cyc();
      reset_n = 1'b1;
      cyc();
      fifo_q.push_back(64'h7777_6666_5555_4242);
      wait_valid("t6_wait2", n);
      chk("t6_hw0", pipe_data, 16'h4242);
      drain(4);
      cyc();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
